// File: rtl/virtio_pkg.sv
// Shared constants, state encoding and helpers for the virtio notify dispatcher.
package virtio_pkg;

    localparam logic [15:0] NO_VECTOR  = 16'hFFFF;
    localparam int          PAGE_SHIFT = 12;
    localparam int          DESC_BYTES = 16;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        REQ,
        WAIT,
        IRQ
    } state_e;

    // Width needed to hold a queue index; never narrower than one bit.
    function automatic int qidx_width(input int nq);
        return (nq > 1) ? $clog2(nq) : 1;
    endfunction

endpackage

// File: rtl/virtio_rr_arbiter.sv
// Round-robin arbiter: picks the first requesting queue at or after ptr, wrapping at NQ.
module virtio_rr_arbiter
    import virtio_pkg::*;
#(
    parameter int NQ = 3,
    parameter int QW = qidx_width(NQ)
) (
    input  logic [NQ-1:0] req,
    input  logic [QW-1:0] ptr,
    output logic [NQ-1:0] grant,
    output logic [QW-1:0] grant_idx,
    output logic          grant_vld
);

    int cand;

    // Scan queues starting at the pointer and grant the first one with a pending request.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = 0;
        for (int i = 0; i < NQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NQ) begin
                cand = cand - NQ;
            end
            if (!grant_vld && req[cand]) begin
                grant_vld   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = QW'(cand);
            end
        end
    end

endmodule

// File: rtl/virtio_notify_dispatch.sv
// Turns driver queue notifies into descriptor-table fetches and MSI-X interrupts,
// coalescing repeat notifies per queue and serving queues round-robin.
module virtio_notify_dispatch
    import virtio_pkg::*;
#(
    parameter int NQ    = 3,
    parameter int QSIZE = 256,
    parameter int CNT_W = 16
) (
    input  logic             clka,
    input  logic             rst,
    input  logic             notify_vld,
    input  logic [15:0]      notify_qidx,
    input  logic             csr_rst,
    input  logic             drv_ok,
    input  logic [NQ*32-1:0] queue_pfn,
    input  logic [NQ*16-1:0] queue_msix,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [63:0]      req_addr,
    output logic [31:0]      req_len,
    output logic [15:0]      req_qidx,
    input  logic             done_vld,
    input  logic [15:0]      done_qidx,
    output logic             irq_valid,
    input  logic             irq_ready,
    output logic [15:0]      irq_vector,
    output logic [NQ-1:0]    pending,
    output logic             busy,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int QW = qidx_width(NQ);

    state_e           state_q, state_d;
    logic [NQ-1:0]    pending_q, pending_d;
    logic [QW-1:0]    ptr_q, ptr_d;
    logic [QW-1:0]    q_q, q_d;
    logic [31:0]      pfn_q, pfn_d;
    logic [15:0]      vec_q, vec_d;
    logic             req_valid_q, req_valid_d;
    logic             irq_valid_q, irq_valid_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [NQ-1:0]    set_mask, clr_mask;
    logic             notify_bad, done_err;
    logic [1:0]       err_inc;
    logic [CNT_W:0]   err_sum;
    logic [31:0]      sel_pfn;

    logic [NQ-1:0]    grant;
    logic [QW-1:0]    grant_idx;
    logic             grant_vld;

    virtio_rr_arbiter #(
        .NQ (NQ),
        .QW (QW)
    ) u_arb (
        .req       (pending_q),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    // Next-state logic: notify capture, service FSM, error accounting and soft reset.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        q_d         = q_q;
        pfn_d       = pfn_q;
        vec_d       = vec_q;
        req_valid_d = req_valid_q;
        irq_valid_d = irq_valid_q;
        set_mask    = '0;
        clr_mask    = '0;
        done_err    = 1'b0;
        sel_pfn     = queue_pfn[32*grant_idx +: 32];

        for (int i = 0; i < NQ; i++) begin
            if (notify_vld && notify_qidx == 16'(i)) begin
                set_mask[i] = 1'b1;
            end
        end
        notify_bad = notify_vld && (notify_qidx >= 16'(NQ));

        case (state_q)
            IDLE: begin
                if (drv_ok && |pending_q) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (grant_vld) begin
                    q_d      = grant_idx;
                    pfn_d    = sel_pfn;
                    vec_d    = queue_msix[16*grant_idx +: 16];
                    clr_mask = grant;
                    ptr_d    = (grant_idx == QW'(NQ - 1)) ? '0 : grant_idx + QW'(1);
                    if (sel_pfn == 32'h0) begin
                        state_d = IDLE;
                    end else begin
                        state_d     = REQ;
                        req_valid_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (req_ready) begin
                    state_d     = WAIT;
                    req_valid_d = 1'b0;
                end
            end
            WAIT: begin
                if (done_vld) begin
                    if (done_qidx == 16'(q_q)) begin
                        state_d     = IRQ;
                        irq_valid_d = (vec_q != NO_VECTOR);
                    end else begin
                        done_err = 1'b1;
                    end
                end
            end
            IRQ: begin
                if (!irq_valid_q || irq_ready) begin
                    state_d     = IDLE;
                    irq_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (done_vld && state_q != WAIT) begin
            done_err = 1'b1;
        end

        pending_d = (pending_q & ~clr_mask) | set_mask;

        if (csr_rst) begin
            state_d     = IDLE;
            pending_d   = '0;
            ptr_d       = '0;
            req_valid_d = 1'b0;
            irq_valid_d = 1'b0;
        end

        err_inc   = {1'b0, notify_bad} + {1'b0, done_err};
        err_sum   = {1'b0, err_cnt_q} + (CNT_W + 1)'(err_inc);
        err_cnt_d = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    end

    // State, latches and counters; everything clears on the asynchronous reset.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            ptr_q       <= '0;
            q_q         <= '0;
            pfn_q       <= '0;
            vec_q       <= '0;
            req_valid_q <= 1'b0;
            irq_valid_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            ptr_q       <= ptr_d;
            q_q         <= q_d;
            pfn_q       <= pfn_d;
            vec_q       <= vec_d;
            req_valid_q <= req_valid_d;
            irq_valid_q <= irq_valid_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign req_valid  = req_valid_q;
    assign req_addr   = req_valid_q ? (64'(pfn_q) << PAGE_SHIFT) : '0;
    assign req_len    = req_valid_q ? 32'(QSIZE * DESC_BYTES) : '0;
    assign req_qidx   = req_valid_q ? 16'(q_q) : '0;
    assign irq_valid  = irq_valid_q;
    assign irq_vector = irq_valid_q ? vec_q : '0;
    assign pending    = pending_q;
    assign busy       = (state_q != IDLE);
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_virtio_notify_dispatch.sv
// Directed testbench for virtio_notify_dispatch.
module tb_virtio_notify_dispatch;

    localparam int NQ = 3;

    logic             clka = 1'b0;
    logic             rst;
    logic             notify_vld;
    logic [15:0]      notify_qidx;
    logic             csr_rst;
    logic             drv_ok;
    logic [NQ*32-1:0] queue_pfn;
    logic [NQ*16-1:0] queue_msix;
    logic             req_valid;
    logic             req_ready;
    logic [63:0]      req_addr;
    logic [31:0]      req_len;
    logic [15:0]      req_qidx;
    logic             done_vld;
    logic [15:0]      done_qidx;
    logic             irq_valid;
    logic             irq_ready;
    logic [15:0]      irq_vector;
    logic [NQ-1:0]    pending;
    logic             busy;
    logic [15:0]      err_cnt;

    int checks = 0;
    int errors = 0;
    int exp_err = 0;

    virtio_notify_dispatch #(
        .NQ    (NQ),
        .QSIZE (256),
        .CNT_W (16)
    ) dut (
        .clka        (clka),
        .rst         (rst),
        .notify_vld  (notify_vld),
        .notify_qidx (notify_qidx),
        .csr_rst     (csr_rst),
        .drv_ok      (drv_ok),
        .queue_pfn   (queue_pfn),
        .queue_msix  (queue_msix),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .req_qidx    (req_qidx),
        .done_vld    (done_vld),
        .done_qidx   (done_qidx),
        .irq_valid   (irq_valid),
        .irq_ready   (irq_ready),
        .irq_vector  (irq_vector),
        .pending     (pending),
        .busy        (busy),
        .err_cnt     (err_cnt)
    );

    always #5 clka = ~clka;

    // Inputs change right after a falling edge; outputs are sampled there too.
    task automatic idle(input int n);
        repeat (n) @(negedge clka);
    endtask

    task automatic pulse_notify(input logic [15:0] q);
        notify_vld  = 1'b1;
        notify_qidx = q;
        @(negedge clka);
        notify_vld  = 1'b0;
    endtask

    task automatic pulse_csr_rst();
        csr_rst = 1'b1;
        @(negedge clka);
        csr_rst = 1'b0;
    endtask

    task automatic wait_req(output logic seen);
        int n;
        n = 0;
        while (!req_valid && n < 20) begin
            @(negedge clka);
            n++;
        end
        seen = req_valid;
    endtask

    // Runs one full transaction (request handshake, completion, interrupt) and reports what was seen.
    task automatic serve_one(output logic [15:0] qidx, output logic [63:0] addr,
                             output logic got_irq, output logic [15:0] vec, output logic timeout);
        logic seen;
        qidx = '0; addr = '0; got_irq = 1'b0; vec = '0; timeout = 1'b1;
        wait_req(seen);
        if (!seen) return;
        timeout   = 1'b0;
        qidx      = req_qidx;
        addr      = req_addr;
        req_ready = 1'b1;
        @(negedge clka);
        req_ready = 1'b0;
        done_vld  = 1'b1;
        done_qidx = qidx;
        @(negedge clka);
        done_vld  = 1'b0;
        if (irq_valid) begin
            got_irq   = 1'b1;
            vec       = irq_vector;
            irq_ready = 1'b1;
            @(negedge clka);
            irq_ready = 1'b0;
        end else begin
            @(negedge clka);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        checks++;
        if ({req_valid, irq_valid, busy, pending} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b required 000000", {req_valid, irq_valid, busy, pending});
        end
        checks++;
        if (err_cnt !== 16'h0 || req_addr !== 64'h0 || req_len !== 32'h0 || irq_vector !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: err=%h addr=%h len=%h vec=%h required all 0", err_cnt, req_addr, req_len, irq_vector);
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_basic();
        logic [15:0] q, v;
        logic [63:0] a;
        logic gi, to;
        drv_ok = 1'b1;
        pulse_notify(16'd1);
        checks++;
        if (pending !== 3'b010 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_capture: pending=%b busy=%b required 010/0", pending, busy);
        end
        idle(1);
        checks++;
        if (req_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_arb: req_valid=%b busy=%b required 0/1", req_valid, busy);
        end
        idle(1);
        checks++;
        if (req_valid !== 1'b1 || req_addr !== 64'h12345000 || req_len !== 32'd4096 || req_qidx !== 16'd1) begin
            errors++;
            $display("[TB] FAIL basic_req: valid=%b addr=%h len=%0d q=%0d required 1/12345000/4096/1", req_valid, req_addr, req_len, req_qidx);
        end
        checks++;
        if (pending !== 3'b000) begin
            errors++;
            $display("[TB] FAIL basic_clear: pending=%b required 000", pending);
        end
        serve_one(q, a, gi, v, to);
        checks++;
        if (to !== 1'b0 || gi !== 1'b1 || v !== 16'd2 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_irq: timeout=%b irq=%b vec=%h busy=%b required 0/1/0002/0", to, gi, v, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] q, v;
        logic [63:0] a;
        logic gi, to;
        logic [15:0] order1 [3];
        logic [15:0] vecs1  [3];
        logic [15:0] order2 [2];
        order1[0] = 16'd0; order1[1] = 16'd1; order1[2] = 16'd2;
        vecs1[0]  = 16'h0010; vecs1[1] = 16'h0002; vecs1[2] = 16'h0012;
        order2[0] = 16'd0; order2[1] = 16'd2;
        pulse_csr_rst();
        pulse_notify(16'd0);
        pulse_notify(16'd1);
        pulse_notify(16'd2);
        for (int k = 0; k < 3; k++) begin
            serve_one(q, a, gi, v, to);
            checks++;
            if (to !== 1'b0 || q !== order1[k] || v !== vecs1[k]) begin
                errors++;
                $display("[TB] FAIL rr_burst1[%0d]: timeout=%b q=%0d vec=%h required 0/%0d/%h", k, to, q, v, order1[k], vecs1[k]);
            end
        end
        pulse_notify(16'd2);
        pulse_notify(16'd0);
        for (int k = 0; k < 2; k++) begin
            serve_one(q, a, gi, v, to);
            checks++;
            if (to !== 1'b0 || q !== order2[k]) begin
                errors++;
                $display("[TB] FAIL rr_burst2[%0d]: timeout=%b q=%0d required 0/%0d", k, to, q, order2[k]);
            end
        end
    endtask

    task automatic test_drv_ok_gate();
        logic [15:0] q, v;
        logic [63:0] a;
        logic gi, to, extra;
        drv_ok = 1'b0;
        pulse_notify(16'd2);
        pulse_notify(16'd2);
        pulse_notify(16'd2);
        idle(3);
        checks++;
        if (pending !== 3'b100 || busy !== 1'b0 || req_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drvok_hold: pending=%b busy=%b req=%b required 100/0/0", pending, busy, req_valid);
        end
        drv_ok = 1'b1;
        serve_one(q, a, gi, v, to);
        checks++;
        if (to !== 1'b0 || q !== 16'd2 || a !== 64'h33333000) begin
            errors++;
            $display("[TB] FAIL drvok_fetch: timeout=%b q=%0d addr=%h required 0/2/33333000", to, q, a);
        end
        extra = 1'b0;
        repeat (10) begin
            @(negedge clka);
            if (req_valid) extra = 1'b1;
        end
        checks++;
        if (extra !== 1'b0 || pending !== 3'b000) begin
            errors++;
            $display("[TB] FAIL drvok_single: extra_req=%b pending=%b required 0/000", extra, pending);
        end
    endtask

    task automatic test_renotify();
        logic [15:0] q, v;
        logic [63:0] a;
        logic gi, to;
        pulse_notify(16'd1);
        idle(1);
        pulse_notify(16'd1);
        checks++;
        if (req_valid !== 1'b1 || pending !== 3'b010) begin
            errors++;
            $display("[TB] FAIL renotify_setwins: req=%b pending=%b required 1/010", req_valid, pending);
        end
        for (int k = 0; k < 2; k++) begin
            serve_one(q, a, gi, v, to);
            checks++;
            if (to !== 1'b0 || q !== 16'd1 || gi !== 1'b1) begin
                errors++;
                $display("[TB] FAIL renotify_serve[%0d]: timeout=%b q=%0d irq=%b required 0/1/1", k, to, q, gi);
            end
        end
        checks++;
        if (pending !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL renotify_end: pending=%b busy=%b required 000/0", pending, busy);
        end
    endtask

    task automatic test_no_vector_stall();
        logic [15:0] q, v;
        logic [63:0] a;
        logic gi, to, seen, stable, saw_irq;
        queue_msix[31:16] = 16'hFFFF;
        queue_pfn[63:32]  = 32'h000ABCDE;
        pulse_notify(16'd1);
        wait_req(seen);
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $display("[TB] FAIL novec_req: req_valid=%b required 1", seen);
        end
        stable = 1'b1;
        repeat (10) begin
            @(negedge clka);
            if (req_valid !== 1'b1 || req_addr !== 64'hABCDE000 || req_qidx !== 16'd1 || req_len !== 32'd4096)
                stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("[TB] FAIL novec_stable: stable=%b required 1 (last addr=%h)", stable, req_addr);
        end
        serve_one(q, a, gi, v, to);
        saw_irq = gi;
        repeat (10) begin
            @(negedge clka);
            if (irq_valid) saw_irq = 1'b1;
        end
        checks++;
        if (to !== 1'b0 || saw_irq !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL novec_noirq: timeout=%b irq=%b busy=%b required 0/0/0", to, saw_irq, busy);
        end
        queue_msix[31:16] = 16'h0002;
        queue_pfn[63:32]  = 32'h00012345;
    endtask

    task automatic test_errors();
        logic saw_req, saw_irq;
        pulse_notify(16'd5);
        exp_err++;
        checks++;
        if (pending !== 3'b000 || err_cnt !== 16'(exp_err)) begin
            errors++;
            $display("[TB] FAIL err_badq: pending=%b err=%0d required 000/%0d", pending, err_cnt, exp_err);
        end
        queue_pfn[31:0] = 32'h0;
        pulse_notify(16'd0);
        saw_req = 1'b0;
        saw_irq = 1'b0;
        repeat (10) begin
            @(negedge clka);
            if (req_valid) saw_req = 1'b1;
            if (irq_valid) saw_irq = 1'b1;
        end
        checks++;
        if (saw_req !== 1'b0 || saw_irq !== 1'b0 || pending !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_pfn0: req=%b irq=%b pending=%b busy=%b required 0/0/000/0", saw_req, saw_irq, pending, busy);
        end
        queue_pfn[31:0] = 32'h00011111;
    endtask

    task automatic test_csr_reset();
        logic seen, saw_irq;
        pulse_notify(16'd1);
        wait_req(seen);
        pulse_csr_rst();
        checks++;
        if (seen !== 1'b1 || req_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL csr_in_req: seen=%b req=%b busy=%b required 1/0/0", seen, req_valid, busy);
        end
        pulse_notify(16'd1);
        wait_req(seen);
        req_ready = 1'b1;
        @(negedge clka);
        req_ready = 1'b0;
        done_vld  = 1'b1;
        done_qidx = 16'd2;
        @(negedge clka);
        done_vld  = 1'b0;
        exp_err++;
        checks++;
        if (busy !== 1'b1 || irq_valid !== 1'b0 || err_cnt !== 16'(exp_err)) begin
            errors++;
            $display("[TB] FAIL csr_wait_mismatch: busy=%b irq=%b err=%0d required 1/0/%0d", busy, irq_valid, err_cnt, exp_err);
        end
        pulse_notify(16'd0);
        checks++;
        if (pending !== 3'b001) begin
            errors++;
            $display("[TB] FAIL csr_pending_before: pending=%b required 001", pending);
        end
        pulse_csr_rst();
        checks++;
        if (busy !== 1'b0 || pending !== 3'b000) begin
            errors++;
            $display("[TB] FAIL csr_in_wait: busy=%b pending=%b required 0/000", busy, pending);
        end
        done_vld  = 1'b1;
        done_qidx = 16'd1;
        @(negedge clka);
        done_vld  = 1'b0;
        exp_err++;
        saw_irq = irq_valid;
        repeat (5) begin
            @(negedge clka);
            if (irq_valid) saw_irq = 1'b1;
        end
        checks++;
        if (saw_irq !== 1'b0 || err_cnt !== 16'(exp_err) || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL csr_late_done: irq=%b err=%0d busy=%b required 0/%0d/0", saw_irq, err_cnt, busy, exp_err);
        end
    endtask

    task automatic test_err_saturate();
        notify_vld  = 1'b1;
        notify_qidx = 16'd7;
        done_vld    = 1'b1;
        done_qidx   = 16'd0;
        @(negedge clka);
        exp_err += 2;
        checks++;
        if (err_cnt !== 16'(exp_err)) begin
            errors++;
            $display("[TB] FAIL sat_double: err=%0d required %0d", err_cnt, exp_err);
        end
        repeat (33000) @(negedge clka);
        checks++;
        if (err_cnt !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL sat_reach: err=%h required ffff", err_cnt);
        end
        notify_vld = 1'b0;
        done_vld   = 1'b0;
        pulse_notify(16'd9);
        checks++;
        if (err_cnt !== 16'hFFFF || pending !== 3'b000) begin
            errors++;
            $display("[TB] FAIL sat_hold: err=%h pending=%b required ffff/000", err_cnt, pending);
        end
    endtask

    initial begin
        rst         = 1'b1;
        notify_vld  = 1'b0;
        notify_qidx = '0;
        csr_rst     = 1'b0;
        drv_ok      = 1'b0;
        queue_pfn   = {32'h00033333, 32'h00012345, 32'h00011111};
        queue_msix  = {16'h0012, 16'h0002, 16'h0010};
        req_ready   = 1'b0;
        done_vld    = 1'b0;
        done_qidx   = '0;
        irq_ready   = 1'b0;
        @(negedge clka);
        test_reset();
        test_basic();
        test_round_robin();
        test_drv_ok_gate();
        test_renotify();
        test_no_vector_stall();
        test_errors();
        test_csr_reset();
        test_err_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, required finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
